servo_motion_sequencer: RTL and testbench

Sequences servo position commands for the hobby-servo PWM path. It accepts one command at a time over a valid/ready handshake and slews the commanded pulse width toward the target by a bounded step per 20 ms frame. It then dwells for a programmed number of frames and signals completion. It owns the frame timebase and drives `pulse_cycles` and `frame_start` to the downstream PWM generator. Pulse-width changes occur only at frame boundaries, so no partial pulse is ever emitted.

---
 rtl/servo_motion_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_servo_motion_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_motion_sequencer.sv
// ---------------------------------------------------------------------------
// servo_motion_sequencer
//
// Sequences hobby-servo position commands. One command is accepted at a time;
// the commanded pulse width is slewed toward the target by at most
// STEP_CYCLES per frame, then held for a programmed number of dwell frames,
// after which a one-cycle done pulse is issued. The block owns the frame
// timebase, so pulse-width changes only ever land on frame boundaries and the
// downstream PWM generator never emits a partial pulse.
//
// Optional feature (compile-time macro SERVO_SEQ_ABORT_EN):
//   adds input cmd_abort, which cancels an in-flight command and freezes the
//   pulse width at its present value.
//
// Ports:
//   clk           in   1   clock
//   rst_n         in   1   asynchronous active-low reset
//   cmd_valid     in   1   command present
//   cmd_ready     out  1   command accepted when high together with cmd_valid
//   cmd_pos       in   3   target position 0..7
//   cmd_hold      in   8   dwell frames after the target is reached
//   cmd_abort     in   1   (SERVO_SEQ_ABORT_EN only) cancel current command
//   pulse_cycles  out 16   current pulse width in clock cycles
//   frame_start   out  1   high for the cycle in which the frame counter is 0
//   busy          out  1   high whenever the sequencer is not idle
//   done          out  1   one-cycle pulse when a command completes
//   state_dbg     out  2   current FSM state (0 idle, 1 move, 2 dwell)
// ---------------------------------------------------------------------------
module servo_motion_sequencer #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int FRAME_US    = 20000,
    parameter int MIN_US      = 1000,
    parameter int MAX_US      = 2000,
    parameter int STEP_CYCLES = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_pos,
    input  logic [7:0]  cmd_hold,
`ifdef SERVO_SEQ_ABORT_EN
    input  logic        cmd_abort,
`endif
    output logic [15:0] pulse_cycles,
    output logic        frame_start,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state_dbg
);

    localparam int CPU       = CLK_FREQ_HZ / 1000000;
    localparam int FRAME_CYC = FRAME_US * CPU;

    localparam logic [17:0] FRAME_LAST = 18'(FRAME_CYC - 1);
    localparam logic [15:0] MIN_CYC    = 16'(MIN_US * CPU);
    localparam logic [15:0] STEP16     = 16'(STEP_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    // Target pulse width for a position. Positions 0..6 are spaced 125 us
    // apart from MIN_US; position 7 is pinned to MAX_US so the full range is
    // reachable regardless of how the spacing divides it.
    function automatic logic [15:0] pos_to_cycles(input logic [2:0] pos);
        int us;
        if (pos == 3'd7) begin
            us = MAX_US;
        end else begin
            us = MIN_US + 125 * int'(pos);
        end
        return 16'(us * CPU);
    endfunction

    // -----------------------------------------------------------------------
    // Frame timebase
    // -----------------------------------------------------------------------
    logic [17:0] frame_cnt;
    logic        boundary;

    // The boundary is the edge on which the counter wraps, so anything updated
    // on it becomes visible in the same cycle as frame_start.
    assign boundary    = (frame_cnt == FRAME_LAST);
    assign frame_start = (frame_cnt == 18'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (boundary) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + 18'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Abort request (absent in the default build)
    // -----------------------------------------------------------------------
    logic abort_req;
`ifdef SERVO_SEQ_ABORT_EN
    assign abort_req = cmd_abort;
`else
    assign abort_req = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Sequencer state
    // -----------------------------------------------------------------------
    state_t      state, state_nx;
    logic [15:0] cur, cur_nx;
    logic [15:0] target, target_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        done_q, done_nx;

    // Slew arithmetic, unsigned and compare-then-subtract so it never wraps.
    // The step is clipped to the remaining distance, which is what keeps cur
    // from overshooting the target.
    logic        going_up;
    logic [15:0] diff;
    logic [15:0] step;
    logic [15:0] slewed;

    always_comb begin
        going_up = (target >= cur);
        diff     = going_up ? (target - cur) : (cur - target);
        step     = (diff > STEP16) ? STEP16 : diff;
        slewed   = going_up ? (cur + step) : (cur - step);
    end

    // Handshake: a command transfers on a rising clk edge where cmd_valid and
    // cmd_ready are both high. cmd_ready is a pure function of the state (high
    // only in IDLE); cmd_valid seen while busy is dropped, never queued.
    always_comb begin
        state_nx  = state;
        cur_nx    = cur;
        target_nx = target;
        cnt_nx    = cnt;
        done_nx   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    target_nx = pos_to_cycles(cmd_pos);
                    cnt_nx    = cmd_hold;
                    state_nx  = ST_MOVE;
                end
            end

            ST_MOVE: begin
                // Abort wins over a coincident boundary: no slew on that edge.
                if (abort_req) begin
                    state_nx = ST_IDLE;
                end else if (boundary) begin
                    cur_nx = slewed;
                    // A zero-distance move also lands here on its first
                    // boundary, so every command spends at least one frame.
                    if (slewed == target) begin
                        if (cnt == 8'd0) begin
                            state_nx = ST_IDLE;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = ST_DWELL;
                        end
                    end
                end
            end

            ST_DWELL: begin
                if (abort_req) begin
                    state_nx = ST_IDLE;
                end else if (boundary) begin
                    // cnt is at least 1 on entry; treating 0 like 1 keeps an
                    // impossible value from locking the FSM in DWELL.
                    if (cnt <= 8'd1) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt - 8'd1;
                    end
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cur    <= MIN_CYC;
            target <= MIN_CYC;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cur    <= cur_nx;
            target <= target_nx;
            cnt    <= cnt_nx;
            done_q <= done_nx;
        end
    end

    assign cmd_ready    = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign done         = done_q;
    assign pulse_cycles = cur;
    assign state_dbg    = state;

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// ---------------------------------------------------------------------------
// tb_servo_motion_sequencer
//
// Directed bench for servo_motion_sequencer at 1 MHz with STEP_CYCLES=100,
// so pos0 = 1000 and pos7 = 2000 cycles. The frame is shortened to 1000 us
// (1000 cycles) to keep the run short; slew arithmetic does not depend on
// the frame length.
//
// Every frame_start cycle that follows a boundary of an active command
// (busy, or the done cycle) pops one {last, pulse} entry from exp_q and
// compares pulse_cycles and done against it.
// ---------------------------------------------------------------------------
module tb_servo_motion_sequencer;

  localparam int FRAME_CYC = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_pos = '0;
  logic [7:0]  cmd_hold = '0;
`ifdef SERVO_SEQ_ABORT_EN
  logic        cmd_abort = 1'b0;
`endif
  logic        cmd_ready;
  logic [15:0] pulse_cycles;
  logic        frame_start;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  logic [16:0] exp_q[$];
  logic [16:0] exp_e;
  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  servo_motion_sequencer #(
    .CLK_FREQ_HZ(1000000),
    .FRAME_US   (1000),
    .MIN_US     (1000),
    .MAX_US     (2000),
    .STEP_CYCLES(100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_pos     (cmd_pos),
    .cmd_hold    (cmd_hold),
`ifdef SERVO_SEQ_ABORT_EN
    .cmd_abort   (cmd_abort),
`endif
    .pulse_cycles(pulse_cycles),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_pulse(input int value, input bit last);
    exp_q.push_back({last, 16'(value)});
  endtask

  // ---------------- driver tasks ----------------
  // Move to a point a few cycles after a frame start so an accept never
  // lands on a boundary edge.
  task automatic align();
    int n = 0;
    while (!frame_start && n < 3 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (!frame_start && n < 3 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic issue(input logic [2:0] pos, input logic [7:0] hold);
    int n = 0;
    while (!cmd_ready && n < 3 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_pos   = pos;
    cmd_hold  = hold;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("accept_busy", int'(busy), 1);
  endtask

  task automatic wait_done(input int frames, input string name);
    int n = 0;
    while (!done && n < (frames + 1) * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(done), 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && frame_start && (busy || done)) begin
      if (done) done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_unexpected: got pulse=%0d done=%0d busy=%0d, required no active frame",
                 pulse_cycles, done, busy);
      end else begin
        exp_e = exp_q.pop_front();
        check("frame_pulse", int'(pulse_cycles), int'(exp_e[15:0]));
        check("frame_done", int'(done), int'(exp_e[16]));
        if (done) check("done_ready", int'(cmd_ready), 1);
      end
    end else if (rst_n && done) begin
      done_seen++;
      check("done_on_frame_start", int'(frame_start), 1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int exp_dones;
    int i;
    exp_dones = 0;

    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_pulse", int'(pulse_cycles), 1000);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_frame_start", int'(frame_start), 1);
    check("rst_state", int'(state_dbg), 0);

    // frame_start period
    for (i = 1; i < 1500; i++) begin
      @(negedge clk);
      if (frame_start) break;
    end
    check("frame_period", i, FRAME_CYC);

    // pos 3 from 1000, last step partial (75)
    align();
    expect_pulse(1100, 0);
    expect_pulse(1200, 0);
    expect_pulse(1300, 0);
    expect_pulse(1375, 1);
    issue(3'd3, 8'd0);
    wait_done(4, "done_pos3");
    exp_dones++;

    // same position, hold 3: one zero-move frame plus three dwell frames
    align();
    expect_pulse(1375, 0);
    expect_pulse(1375, 0);
    expect_pulse(1375, 0);
    expect_pulse(1375, 1);
    issue(3'd3, 8'd3);
    wait_done(4, "done_hold3");
    exp_dones++;

    // back down to pos 0
    align();
    expect_pulse(1275, 0);
    expect_pulse(1175, 0);
    expect_pulse(1075, 0);
    expect_pulse(1000, 1);
    issue(3'd0, 8'd0);
    wait_done(4, "done_pos0");
    exp_dones++;

    // full-range move to pos 7 with an ignored command while busy
    align();
    for (int k = 1; k <= 10; k++) expect_pulse(1000 + 100 * k, k == 10);
    issue(3'd7, 8'd0);
    wait_frame();
    wait_frame();
    @(negedge clk);
    check("busy_not_ready", int'(cmd_ready), 0);
    cmd_valid = 1'b1;
    cmd_pos   = 3'd0;
    cmd_hold  = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(10, "done_pos7");
    exp_dones++;
    repeat (3 * FRAME_CYC) @(negedge clk);
    check("pos7_held", int'(pulse_cycles), 2000);
    check("idle_after_pos7", int'(busy), 0);

`ifdef SERVO_SEQ_ABORT_EN
    align();
    for (int k = 1; k <= 10; k++) expect_pulse(2000 - 100 * k, k == 10);
    issue(3'd0, 8'd0);
    wait_done(10, "done_return");
    exp_dones++;

    align();
    expect_pulse(1100, 0);
    expect_pulse(1200, 0);
    expect_pulse(1300, 0);
    issue(3'd7, 8'd0);
    wait_frame();
    wait_frame();
    wait_frame();
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_state", int'(state_dbg), 0);
    check("abort_pulse", int'(pulse_cycles), 1300);
    repeat (2 * FRAME_CYC) @(negedge clk);
    check("abort_pulse_frozen", int'(pulse_cycles), 1300);
`endif

    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_seen, exp_dones);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
